// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order branch resolution queue with BHT update and mispredict flush
//
// Tracks in-flight branch predictions in a small FIFO of {pred_taken, pred_hist}.
// When the execute stage resolves the oldest branch, the entry is popped and a
// registered BHT update strobe is emitted; a wrong prediction also raises a
// one-cycle mispredict strobe, squashes every younger entry and reports the
// corrected global history.
//
// Optional feature: define BRANCH_RESOLVER_STATS_EN to build saturating
// hit/miss prediction counters; otherwise hit_cnt and miss_cnt are tied to 0.
//
// Parameters:
//   DEPTH        in-flight queue entries, power of two, 2..16
//   HIST_W       global history width (= BHT index width)
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   pred_valid   prediction issued for a fetched branch
//   pred_taken   predicted direction (1 = taken)
//   pred_hist    history used for the BHT lookup
//   pred_ready   queue can accept a prediction (not full)
//   res_valid    oldest in-flight branch resolves this cycle
//   res_taken    actual outcome
//   upd_valid    one-cycle BHT update strobe
//   upd_index    BHT entry to update (stored pred_hist)
//   upd_outcome  outcome for the BHT counter
//   mispredict   one-cycle flush strobe
//   rec_hist     corrected history after a mispredict (held otherwise)
//   flush_count  younger entries squashed by the mispredict
//   occupancy    current entry count
//   hit_cnt      correct predictions (saturating, stats build only)
//   miss_cnt     mispredictions (saturating, stats build only)

module branch_resolver #(
    parameter int DEPTH  = 4,
    parameter int HIST_W = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    input  logic [HIST_W-1:0]        pred_hist,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic [HIST_W-1:0]        upd_index,
    output logic                     upd_outcome,
    output logic                     mispredict,
    output logic [HIST_W-1:0]        rec_hist,
    output logic [$clog2(DEPTH):0]   flush_count,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               hit_cnt,
    output logic [7:0]               miss_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Entry layout: bit HIST_W is the predicted direction, the rest is history.
    logic [HIST_W:0]       mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  mis_now;
    logic                  head_taken;
    logic [HIST_W-1:0]     head_hist;
    logic [HIST_W-1:0]     rec_next;
    logic [OCC_W-1:0]      occ_next;

    // Readiness comes from the registered count only, so a same-cycle pop never
    // opens a slot for a push while the queue is full.
    assign full       = (occupancy == OCC_W'(DEPTH));
    assign pred_ready = ~full;

    assign head_taken = mem[rd_ptr][HIST_W];
    assign head_hist  = mem[rd_ptr][HIST_W-1:0];

    // Pop only a resident entry; on an empty queue res_valid is ignored, which
    // also guarantees a same-cycle push is never consumed immediately.
    assign pop     = res_valid & (occupancy != '0);
    assign mis_now = pop & (head_taken != res_taken);

    // A mispredict squashes the whole queue, including a push arriving with it.
    assign push    = pred_valid & pred_ready & ~mis_now;

    // Corrected history: shift the resolved outcome into the stored history.
    generate
        if (HIST_W > 1) begin : g_rec_shift
            assign rec_next = {head_hist[HIST_W-2:0], res_taken};
        end else begin : g_rec_bit
            assign rec_next = res_taken;
        end
    endgenerate

    always_comb begin
        occ_next = occupancy;
        if (mis_now) begin
            occ_next = '0;
        end else begin
            occ_next = occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Queue storage carries no reset: pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pred_taken, pred_hist};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (mis_now) begin
                // Discard everything younger by jumping the read side to the
                // write side; wr_ptr does not move since the push was dropped.
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_valid   <= 1'b0;
            upd_index   <= '0;
            upd_outcome <= 1'b0;
            mispredict  <= 1'b0;
            rec_hist    <= '0;
            flush_count <= '0;
        end else begin
            upd_valid   <= pop;
            mispredict  <= mis_now;
            flush_count <= mis_now ? (occupancy - OCC_W'(1)) : '0;
            if (pop) begin
                upd_index   <= head_hist;
                upd_outcome <= res_taken;
            end
            if (mis_now) begin
                rec_hist <= rec_next;
            end
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [7:0] hit_q;
    logic [7:0] miss_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (pop && !mis_now && hit_q != 8'hff) begin
                hit_q <= hit_q + 8'd1;
            end
            if (mis_now && miss_q != 8'hff) begin
                miss_q <= miss_q + 8'd1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = 8'd0;
    assign miss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver

module tb_branch_resolver;

    localparam int DEPTH  = 4;
    localparam int HIST_W = 2;

`ifdef BRANCH_RESOLVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              pred_valid;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_hist;
    logic              pred_ready;
    logic              res_valid;
    logic              res_taken;
    logic              upd_valid;
    logic [HIST_W-1:0] upd_index;
    logic              upd_outcome;
    logic              mispredict;
    logic [HIST_W-1:0] rec_hist;
    logic [2:0]        flush_count;
    logic [2:0]        occupancy;
    logic [7:0]        hit_cnt;
    logic [7:0]        miss_cnt;

    int vectors;
    int miscompares;

    branch_resolver #(.DEPTH(DEPTH), .HIST_W(HIST_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_hist   (pred_hist),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .upd_valid   (upd_valid),
        .upd_index   (upd_index),
        .upd_outcome (upd_outcome),
        .mispredict  (mispredict),
        .rec_hist    (rec_hist),
        .flush_count (flush_count),
        .occupancy   (occupancy),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs
    // are sampled here, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic t, input logic [HIST_W-1:0] h);
        pred_valid = 1'b1;
        pred_taken = t;
        pred_hist  = h;
        step();
        pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic t);
        res_valid = 1'b1;
        res_taken = t;
        step();
        res_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b1;
        pred_valid  = 1'b0;
        pred_taken  = 1'b0;
        pred_hist   = '0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;

        // Asynchronous reset takes effect before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_pred_ready", pred_ready, 1);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_flush_count", flush_count, 0);
        chk("rst_rec_hist", rec_hist, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Single correct taken branch.
        push(1'b1, 2'b01);
        chk("t1_occupancy", occupancy, 1);
        chk("t1_no_upd_yet", upd_valid, 0);
        resolve(1'b1);
        chk("t1_upd_valid", upd_valid, 1);
        chk("t1_upd_index", upd_index, 2'b01);
        chk("t1_upd_outcome", upd_outcome, 1);
        chk("t1_mispredict", mispredict, 0);
        chk("t1_flush_count", flush_count, 0);
        chk("t1_occupancy_after", occupancy, 0);
        step();
        chk("t1_upd_one_cycle", upd_valid, 0);

        // Fill to DEPTH, overflow push ignored, full + pop admits no push.
        for (int i = 0; i < DEPTH; i++) begin
            push(1'b1, HIST_W'(i));
        end
        chk("full_occupancy", occupancy, 4);
        chk("full_pred_ready", pred_ready, 0);
        pred_valid = 1'b1;
        pred_taken = 1'b0;
        pred_hist  = 2'b11;
        step();
        chk("full_5th_ignored", occupancy, 4);
        res_valid = 1'b1;
        res_taken = 1'b1;
        step();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        chk("full_pop_push_occ", occupancy, 3);
        chk("full_pop_ready", pred_ready, 1);
        chk("full_pop_index0", upd_index, 2'b00);
        resolve(1'b1);
        chk("fifo_index1", upd_index, 2'b01);
        resolve(1'b1);
        chk("fifo_index2", upd_index, 2'b10);
        resolve(1'b1);
        chk("fifo_index3", upd_index, 2'b11);
        chk("fifo_drained", occupancy, 0);
        chk("fifo_hits", hit_cnt, STATS ? 5 : 0);

        // Mispredict on the oldest of three entries, with a same-cycle push.
        push(1'b0, 2'b10);
        push(1'b1, 2'b01);
        push(1'b1, 2'b11);
        pred_valid = 1'b1;
        pred_taken = 1'b1;
        pred_hist  = 2'b00;
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        step();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        chk("mis_mispredict", mispredict, 1);
        chk("mis_flush_count", flush_count, 2);
        chk("mis_rec_hist", rec_hist, 2'b01);
        chk("mis_upd_index", upd_index, 2'b10);
        chk("mis_upd_outcome", upd_outcome, 1);
        chk("mis_occupancy", occupancy, 0);
        chk("mis_miss_cnt", miss_cnt, STATS ? 1 : 0);
        step();
        chk("mis_one_cycle", mispredict, 0);
        chk("mis_flush_clear", flush_count, 0);
        chk("mis_rec_hold", rec_hist, 2'b01);
        chk("mis_still_empty", occupancy, 0);

        // Resolve on empty queue: ignored; with a push the new entry stays.
        resolve(1'b1);
        chk("empty_no_upd", upd_valid, 0);
        chk("empty_no_mis", mispredict, 0);
        chk("empty_occ", occupancy, 0);
        pred_valid = 1'b1;
        pred_taken = 1'b0;
        pred_hist  = 2'b11;
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        step();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        chk("empty_push_occ", occupancy, 1);
        chk("empty_push_no_upd", upd_valid, 0);
        resolve(1'b0);
        chk("nt_upd_index", upd_index, 2'b11);
        chk("nt_upd_outcome", upd_outcome, 0);
        chk("nt_mispredict", mispredict, 0);

        // Mispredict with a single entry: nothing younger to flush.
        push(1'b1, 2'b10);
        resolve(1'b0);
        chk("mis1_mispredict", mispredict, 1);
        chk("mis1_flush_count", flush_count, 0);
        chk("mis1_rec_hist", rec_hist, 2'b00);
        chk("mis1_miss_cnt", miss_cnt, STATS ? 2 : 0);

        // Reset with three entries in flight and a pending resolve.
        push(1'b1, 2'b01);
        push(1'b1, 2'b10);
        push(1'b1, 2'b11);
        res_valid = 1'b1;
        res_taken = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_occupancy", occupancy, 0);
        chk("mid_rst_pred_ready", pred_ready, 1);
        step();
        chk("mid_rst_no_upd", upd_valid, 0);
        chk("mid_rst_no_mis", mispredict, 0);
        reset_n   = 1'b1;
        res_valid = 1'b0;
        step();
        chk("post_rst_no_upd", upd_valid, 0);
        chk("post_rst_occupancy", occupancy, 0);
        chk("post_rst_hit_cnt", hit_cnt, 0);
        chk("post_rst_miss_cnt", miss_cnt, 0);

        // Counter saturation over 300 correct resolutions.
        for (int i = 0; i < 300; i++) begin
            push(1'b1, HIST_W'(i));
            resolve(1'b1);
            if (i == 9) begin
                chk("stats_hit_10", hit_cnt, STATS ? 10 : 0);
            end
        end
        chk("stats_hit_sat", hit_cnt, STATS ? 255 : 0);
        chk("stats_miss_zero", miss_cnt, 0);
        chk("stats_occ_end", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DEPTH, default 4: in-flight branch queue entries; power of two, 2..16.
REQ-002 Parameter HIST_W, default 2: global history width; equals BHT index width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 pred_valid  input  1  predictor issues a prediction for a fetched branch.
REQ-006 pred_taken  input  1  predicted direction; 1 = taken.
REQ-007 pred_hist  input  HIST_W  global history used for the BHT lookup.
REQ-008 pred_ready  output  1  queue can accept a prediction.
REQ-009 res_valid  input  1  execute stage resolves the oldest in-flight branch, in order.
REQ-010 res_taken  input  1  actual outcome.
REQ-011 upd_valid  output  1  one-cycle BHT update strobe.
REQ-012 upd_index  output  HIST_W  BHT entry to update: stored pred_hist.
REQ-013 upd_outcome  output  1  outcome for the BHT FSM.
REQ-014 mispredict  output  1  one-cycle pipeline flush strobe.
REQ-015 rec_hist  output  HIST_W  corrected history: {upd_index[HIST_W-2:0], res_taken}.
REQ-016 flush_count  output  clog2(DEPTH)+1  younger entries squashed on mispredict.
REQ-017 occupancy  output  clog2(DEPTH)+1  current entry count.
REQ-018 hit_cnt, miss_cnt  output  8 each  prediction statistics (see Configuration).

Function
REQ-019 Queue SHALL be an in-order FIFO of {pred_taken, pred_hist}; push on pred_valid & pred_ready.
REQ-020 pred_ready SHALL be combinational !full from registered occupancy; no push when full, even with same-cycle pop.
REQ-021 Pop SHALL occur on res_valid while occupancy != 0; res_valid on empty SHALL be ignored (no strobes, no state change).
REQ-022 Pop on empty with same-cycle push SHALL not pop the newly pushed entry.
REQ-023 upd_valid, upd_index, upd_outcome, mispredict, rec_hist, flush_count SHALL be registered: valid the cycle after the pop, strobes high exactly one cycle.
REQ-024 mispredict SHALL assert when popped pred_taken != res_taken.
REQ-025 On mispredict, all remaining entries SHALL be discarded; flush_count = occupancy before pop minus 1; a same-cycle push SHALL be dropped; occupancy = 0 next cycle.
REQ-026 Without mispredict, flush_count SHALL be 0 and occupancy = old + push - pop.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH.
REQ-028 rec_hist SHALL hold its last value when mispredict is low.

Reset
REQ-029 reset_n low SHALL immediately clear pointers, occupancy, all outputs and counters to 0; pred_ready = 1 after reset.
REQ-030 Reset mid-operation SHALL discard in-flight entries without emitting upd_valid or mispredict.

Configuration
REQ-031 Macro BRANCH_RESOLVER_STATS_EN defined: hit_cnt increments on each correct pop, miss_cnt on each mispredict, both saturating at 255.
REQ-032 Macro undefined: counter logic absent; hit_cnt, miss_cnt tied to 0; all other behaviour identical.

Verification
REQ-033 Push taken/hist=2'b01, resolve taken next cycle -> one cycle later upd_valid=1, upd_index=01, upd_outcome=1, mispredict=0.
REQ-034 Push 4 entries (DEPTH=4) -> pred_ready=0, 5th pred_valid ignored, occupancy=4; pop one -> pred_ready=1.
REQ-035 Push 3 entries, first predicted not-taken hist=2'b10, resolve taken -> mispredict=1, flush_count=2, rec_hist=2'b01, occupancy=0.
REQ-036 res_valid with empty queue -> no upd_valid/mispredict, occupancy stays 0; same-cycle push yields occupancy=1.
REQ-037 Reset_n pulled low with 3 entries in flight -> occupancy=0, pred_ready=1, no strobes.
REQ-038 With BRANCH_RESOLVER_STATS_EN, 300 correct resolutions -> hit_cnt=255, miss_cnt=0; without macro both 0.
